// File: rtl/guess_game_ctrl.sv
// guess_game_ctrl: number-guessing game FSM that captures a random target, scores guesses and locks out after each result
module guess_game_ctrl #(
  parameter int MAX_TRIES   = 5,
  parameter int LOCK_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rand_num,
  input  logic       new_game,
  input  logic [3:0] guess,
  input  logic       guess_pulse,
  output logic       too_high,
  output logic       too_low,
  output logic       win,
  output logic       lose,
  output logic [3:0] attempts_left,
  output logic       game_active,
  output logic       ready,
  output logic [3:0] target_out
);
  typedef enum logic [1:0] {IDLE, PLAY, WIN, LOSE} state_t;
  state_t     state_q;
  logic [3:0] target_q;
  logic [3:0] attempts_q;
  logic [7:0] lock_q;
  logic       too_high_q;
  logic       too_low_q;
  logic       win_q;
  logic       lose_q;
  logic       done;
  assign done          = (state_q == WIN) || (state_q == LOSE);
  assign ready         = !done || (lock_q == 8'd0);
  assign game_active   = (state_q == PLAY);
  assign target_out    = done ? target_q : 4'd0;
  assign too_high      = too_high_q;
  assign too_low       = too_low_q;
  assign win           = win_q;
  assign lose          = lose_q;
  assign attempts_left = attempts_q;
  // Later assignments in this block override the lock countdown when a game ends.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      target_q   <= 4'd0;
      attempts_q <= 4'd0;
      lock_q     <= 8'd0;
      too_high_q <= 1'b0;
      too_low_q  <= 1'b0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
    end else begin
      if (lock_q != 8'd0) lock_q <= lock_q - 8'd1;
      if (ready && new_game) begin
        state_q    <= PLAY;
        target_q   <= rand_num;
        attempts_q <= 4'(MAX_TRIES);
        too_high_q <= 1'b0;
        too_low_q  <= 1'b0;
        win_q      <= 1'b0;
        lose_q     <= 1'b0;
      end else if (state_q == PLAY && guess_pulse && attempts_q != 4'd0) begin
        attempts_q <= attempts_q - 4'd1;
        too_high_q <= guess > target_q;
        too_low_q  <= guess < target_q;
        if (guess == target_q) begin
          win_q   <= 1'b1;
          state_q <= WIN;
          lock_q  <= 8'(LOCK_CYCLES);
        end else if (attempts_q == 4'd1) begin
          lose_q  <= 1'b1;
          state_q <= LOSE;
          lock_q  <= 8'(LOCK_CYCLES);
        end
      end
    end
  end
endmodule

// File: tb/tb_guess_game_ctrl.sv
// tb_guess_game_ctrl: directed and randomized checks of guess_game_ctrl against a game-rules model
module tb_guess_game_ctrl;
  localparam int MAX = 5;
  localparam int LOCK = 8;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] rand_num = '0;
  logic       new_game = 1'b0;
  logic [3:0] guess = '0;
  logic       guess_pulse = 1'b0;
  logic       too_high, too_low, win, lose, game_active, ready;
  logic [3:0] attempts_left, target_out;
  int cmp_cnt = 0;
  int mis_cnt = 0;
  int phase = 0;
  int tgt = 0;
  int left = 0;
  int cyc = 0;
  int end_cyc = 0;
  bit hi = 0, lo = 0, wn = 0, ls = 0;
  guess_game_ctrl #(.MAX_TRIES(MAX), .LOCK_CYCLES(LOCK)) dut (
    .clk(clk), .rst(rst), .rand_num(rand_num), .new_game(new_game),
    .guess(guess), .guess_pulse(guess_pulse), .too_high(too_high),
    .too_low(too_low), .win(win), .lose(lose), .attempts_left(attempts_left),
    .game_active(game_active), .ready(ready), .target_out(target_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int act, input int exp);
    cmp_cnt++;
    if (act != exp) begin
      mis_cnt++;
      $display("FAIL %s cyc=%0d: got %0d, want %0d", tag, cyc, act, exp);
    end
  endtask
  function automatic bit model_ready();
    return phase < 2 || (cyc - end_cyc) >= LOCK;
  endfunction
  task automatic step(input bit r, input bit ng, input bit gp, input int g, input int rn);
    rst = r;
    new_game = ng;
    guess_pulse = gp;
    guess = 4'(g);
    rand_num = 4'(rn);
    @(posedge clk);
    if (!r) begin
      phase = 0; tgt = 0; left = 0; hi = 0; lo = 0; wn = 0; ls = 0;
    end else if (ng && model_ready()) begin
      phase = 1; tgt = rn; left = MAX; hi = 0; lo = 0; wn = 0; ls = 0;
    end else if (phase == 1 && gp) begin
      left--;
      hi = g > tgt;
      lo = g < tgt;
      if (g == tgt) begin
        wn = 1; phase = 2; end_cyc = cyc + 1;
      end else if (left == 0) begin
        ls = 1; phase = 3; end_cyc = cyc + 1;
      end
    end
    cyc++;
    #1;
    chk("too_high", too_high, hi);
    chk("too_low", too_low, lo);
    chk("win", win, wn);
    chk("lose", lose, ls);
    chk("attempts_left", attempts_left, left);
    chk("game_active", game_active, phase == 1);
    chk("ready", ready, model_ready());
    chk("target_out", target_out, phase >= 2 ? tgt : 0);
    chk("exclusive", {win & lose, too_high & too_low}, 0);
  endtask
  initial begin
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 3, 0);
    step(1, 1, 0, 0, 9);
    step(1, 0, 1, 4, 0);
    step(1, 0, 1, 12, 0);
    step(1, 0, 1, 9, 0);
    for (int i = 1; i <= 10; i++) step(1, i == 3 || i == 7, i == 5, 9, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 3);
    for (int i = 0; i < 6; i++) step(1, 0, 1, 7, 0);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 5);
    step(1, 1, 1, 5, 14);
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 15, 0);
    step(1, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 6);
    for (int i = 0; i < 4; i++) step(1, 0, 1, i, 0);
    step(1, 0, 1, 6, 0);
    for (int i = 0; i < 4000; i++)
      step($urandom_range(99) != 0, $urandom_range(19) == 0, $urandom_range(2) == 0,
           $urandom_range(15), $urandom_range(15));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end
endmodule

// File: doc/guess_game_ctrl.md
Name: guess_game_ctrl

Overview:
- Downstream consumer of the 4-bit random number generator in the number-guessing lab design.
- On a new-game request it captures the generator's current value as the secret target.
- It then accepts player guesses from switches via a one-cycle button pulse and reports too-high, too-low, win or lose.
- It tracks remaining attempts and enforces a lockout after each finished game before a new game can start.

Parameters:
- MAX_TRIES, 5, attempts per game; legal range 1..15.
- LOCK_CYCLES, 8, clock cycles the WIN/LOSE result is held before new_game is accepted; legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-low reset.
- rand_num  input  4  current random value from the generator stage.
- new_game  input  1  one-cycle start pulse, active-high.
- guess  input  4  player guess from switches.
- guess_pulse  input  1  one-cycle submit pulse, active-high.
- too_high  output  1  last guess was greater than the target.
- too_low  output  1  last guess was less than the target.
- win  output  1  game won.
- lose  output  1  attempts exhausted without a win.
- attempts_left  output  4  remaining guesses.
- game_active  output  1  high while in PLAY.
- ready  output  1  new_game will be accepted this cycle.
- target_out  output  4  revealed target; 0 unless in WIN/LOSE.

Behaviour:
- Reset is synchronous, active-low: rst==0 at a posedge forces the following.
  - State IDLE; target=0, attempts_left=0, lock counter=0.
  - too_high, too_low, win and lose all 0; target_out=0.
  - Reset mid-game aborts the game immediately with no result flag.
- Registered outputs have 1-cycle latency from the causing pulse. ready and game_active are decoded from current state and lock counter.
- States: IDLE, PLAY, WIN, LOSE.
- IDLE
  - ready=1; guess_pulse is ignored.
  - new_game=1: target<=rand_num (value sampled at that edge), attempts_left<=MAX_TRIES, all flags cleared, go to PLAY.
- PLAY
  - game_active=1, ready=1.
  - new_game=1 (abort/restart): target<=rand_num, attempts_left<=MAX_TRIES, flags cleared, stay in PLAY.
  - new_game and guess_pulse in the same cycle: new_game wins and the guess is discarded.
  - guess_pulse=1, guess==target: win<=1, too_high<=0, too_low<=0, attempts_left<=attempts_left-1, go to WIN.
  - guess_pulse=1, guess>target (unsigned): too_high<=1, too_low<=0, attempts_left decrements.
  - guess_pulse=1, guess<target (unsigned): too_low<=1, too_high<=0, attempts_left decrements.
  - Wrong guess when attempts_left==1: attempts_left<=0, lose<=1, go to LOSE. too_high/too_low still reflect that final guess.
  - too_high/too_low hold their value until the next accepted guess, a new game, or reset.
  - A correct guess on the last attempt is a WIN (attempts_left becomes 0).
- WIN / LOSE
  - Entry loads lock counter with LOCK_CYCLES; it decrements each cycle down to 0 and stops there.
  - target_out=target; win or lose stays asserted; guess_pulse is ignored.
  - ready=1 only when lock counter==0.
  - new_game while locked is ignored; it is not queued.
  - new_game when ready=1 behaves exactly as in IDLE (capture rand_num, go to PLAY, clear flags).
- Arithmetic
  - 4-bit unsigned comparison.
  - attempts_left never underflows; decrement is only possible from values >=1.
  - Lock counter is 8 bits.
- Never asserted simultaneously: win and lose; too_high and too_low.

Test Plan:
- Reset: rst=0 for 2 cycles, then 1 -> all outputs 0, ready=1, game_active=0, target_out=0.
- Win path: rand_num=9, new_game; guesses 4, 12, 9 ->
  - after 4: too_low=1, attempts_left=4.
  - after 12: too_high=1, attempts_left=3.
  - after 9: win=1, attempts_left=2, target_out=9, ready=0 for 8 cycles then 1.
- Lose path: rand_num=3, MAX_TRIES=5, five guesses of 7 -> too_high=1 each time, attempts_left 4,3,2,1,0, lose=1 after the fifth; a sixth guess_pulse changes nothing.
- Collision and abort: in PLAY with target=5, new_game and guess_pulse (guess=5) in the same cycle with rand_num=14 -> target=14, attempts_left=5, win=0, flags 0.
- Lockout: in WIN, new_game pulsed at lock cycles 3 and 7 -> ignored; pulse after ready=1 with rand_num=0 -> PLAY, target 0, win cleared.
- Reset mid-game: PLAY with attempts_left=2, too_low=1, rst=0 one cycle -> IDLE, all outputs 0.
